// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared constants for the decode stage. Holds the opcode and
//                funct field values, ALU operation encodings, the register
//                index width and the output-stage FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Register index width. The register file has 32 entries.
    localparam int REG_W = 5;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes, instruction bits [5:0]
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes. ALU_NOP is what an illegal instruction carries.
    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    // Output pipeline register occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

endpackage : decode_pkg
`default_nettype wire

// File: rtl/decode_stage_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_reg_file
//  Description : Register file for the decode stage. Two asynchronous read
//                ports, one synchronous write port. Entry 0 always reads as
//                zero and ignores writes.
//                Optional macro WB_BYPASS_EN: a read whose index matches an
//                active (non-zero) write in the same cycle returns the write
//                data. Without it the read returns the pre-write contents.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                i_wb_en/addr/data - write port
//                i_rs_addr/i_rt_addr, o_rs_data/o_rt_data - read ports
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_reg_file
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_en,
    input  logic [REG_W-1:0]  i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [REG_W-1:0]  i_rs_addr,
    input  logic [REG_W-1:0]  i_rt_addr,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data
);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              w_wr;
    logic [DATA_W-1:0] w_rs_raw;
    logic [DATA_W-1:0] w_rt_raw;

    assign w_wr = i_wb_en && (i_wb_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    // Entry 0 is never written, but the explicit zero keeps r0 correct
    // independent of what the array holds.
    assign w_rs_raw = (i_rs_addr == '0) ? '0 : r_regs[i_rs_addr];
    assign w_rt_raw = (i_rt_addr == '0) ? '0 : r_regs[i_rt_addr];

`ifdef WB_BYPASS_EN
    // w_wr already excludes r0, so a bypass can never make r0 non-zero.
    assign o_rs_data = (w_wr && (i_wb_addr == i_rs_addr)) ? i_wb_data : w_rs_raw;
    assign o_rt_data = (w_wr && (i_wb_addr == i_rt_addr)) ? i_wb_data : w_rt_raw;
`else
    assign o_rs_data = w_rs_raw;
    assign o_rt_data = w_rt_raw;
`endif

endmodule : decode_stage_reg_file
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Instruction decode stage. Splits the fetched instruction into
//                fields, reads two operands from the register file, derives
//                control signals and holds the result in one output register
//                with a valid/ready handshake toward execute.
//                Optional macro WB_BYPASS_EN: same-cycle writeback-to-read
//                bypass in the register file.
//  Ports       : clk, reset                 - clock, async active-high reset
//                inst_in, pc_in, inst_valid, inst_ready - fetch side
//                flush                      - drop held and incoming instr
//                wb_en, wb_addr, wb_data    - register file write port
//                id_valid, id_ready, id_*   - decoded bundle to execute
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inst_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [REG_W-1:0]  id_rd,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rt_data,
    output logic [DATA_W-1:0] id_imm,
    output logic [3:0]        id_alu_op,
    output logic              id_reg_write,
    output logic              id_mem_read,
    output logic              id_mem_write,
    output logic              id_branch,
    output logic              id_illegal
);

    // ------------------------------------------------------------------
    // Field split
    // ------------------------------------------------------------------
    logic [5:0]       w_opcode;
    logic [REG_W-1:0] w_rs;
    logic [REG_W-1:0] w_rt;
    logic [REG_W-1:0] w_rdf;
    logic [5:0]       w_funct;

    assign w_opcode = inst_in[31:26];
    assign w_rs     = inst_in[25:21];
    assign w_rt     = inst_in[20:16];
    assign w_rdf    = inst_in[15:11];
    assign w_funct  = inst_in[5:0];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    decode_stage_reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_reg_file (
        .clk       (clk),
        .rst       (reset),
        .i_wb_en   (wb_en),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data),
        .i_rs_addr (w_rs),
        .i_rt_addr (w_rt),
        .o_rs_data (w_rs_data),
        .o_rt_data (w_rt_data)
    );

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [3:0]        w_alu_op;
    logic              w_reg_write;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_branch;
    logic              w_illegal;
    logic              w_zext;
    logic [REG_W-1:0]  w_rd;
    logic [DATA_W-1:0] w_imm;

    always_comb begin : p_decode
        w_alu_op    = ALU_NOP;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_illegal   = 1'b0;
        w_zext      = 1'b0;
        w_rd        = w_rt;
        case (w_opcode)
            OP_RTYPE: begin
                w_rd = w_rdf;
                case (w_funct)
                    FN_ADD:  begin w_alu_op = ALU_ADD; w_reg_write = 1'b1; end
                    FN_SUB:  begin w_alu_op = ALU_SUB; w_reg_write = 1'b1; end
                    FN_AND:  begin w_alu_op = ALU_AND; w_reg_write = 1'b1; end
                    FN_OR:   begin w_alu_op = ALU_OR;  w_reg_write = 1'b1; end
                    FN_SLT:  begin w_alu_op = ALU_SLT; w_reg_write = 1'b1; end
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin w_alu_op = ALU_ADD; w_reg_write = 1'b1; end
            OP_ANDI: begin w_alu_op = ALU_AND; w_reg_write = 1'b1; w_zext = 1'b1; end
            OP_ORI:  begin w_alu_op = ALU_OR;  w_reg_write = 1'b1; w_zext = 1'b1; end
            OP_LW:   begin w_alu_op = ALU_ADD; w_reg_write = 1'b1; w_mem_read = 1'b1; end
            OP_SW:   begin w_alu_op = ALU_ADD; w_mem_write = 1'b1; end
            OP_BEQ:  begin w_alu_op = ALU_SUB; w_branch = 1'b1; end
            default: w_illegal = 1'b1;
        endcase
    end

    // Logical immediates zero-extend, everything else sign-extends
    assign w_imm = w_zext ? {{(DATA_W-16){1'b0}}, inst_in[15:0]}
                          : {{(DATA_W-16){inst_in[15]}}, inst_in[15:0]};

    // ------------------------------------------------------------------
    // Handshake and output-register FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   w_transfer;
    logic   w_load;

    assign id_valid   = (r_state != ST_EMPTY);
    assign inst_ready = !id_valid || id_ready;
    assign w_transfer = inst_valid && inst_ready;
    // A flush drops the instruction arriving in the same cycle
    assign w_load     = w_transfer && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin : p_fsm_next
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_transfer) w_state_next = ST_FULL;
                end
                ST_FULL, ST_STALL: begin
                    if (!id_ready)       w_state_next = ST_STALL;
                    else if (w_transfer) w_state_next = ST_FULL;
                    else                 w_state_next = ST_EMPTY;
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Output register. Loading requires inst_ready, which is low whenever a
    // held bundle is not being accepted, so a stalled bundle stays frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_pc        <= '0;
            id_rd        <= '0;
            id_rs_data   <= '0;
            id_rt_data   <= '0;
            id_imm       <= '0;
            id_alu_op    <= '0;
            id_reg_write <= 1'b0;
            id_mem_read  <= 1'b0;
            id_mem_write <= 1'b0;
            id_branch    <= 1'b0;
            id_illegal   <= 1'b0;
        end else if (w_load) begin
            id_pc        <= pc_in;
            id_rd        <= w_rd;
            id_rs_data   <= w_rs_data;
            id_rt_data   <= w_rt_data;
            id_imm       <= w_imm;
            id_alu_op    <= w_alu_op;
            id_reg_write <= w_reg_write;
            id_mem_read  <= w_mem_read;
            id_mem_write <= w_mem_write;
            id_branch    <= w_branch;
            id_illegal   <= w_illegal;
        end
    end

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage. Directed scenarios plus
//                a randomized run, all checked against a transaction-level
//                model of the stage (one held bundle plus a register array).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] inst_in = '0;
    logic [4:0]  pc_in = '0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [4:0]  id_pc;
    logic [4:0]  id_rd;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_op;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_branch;
    logic        id_illegal;

    decode_stage dut (
        .clk          (clk),
        .reset        (reset),
        .inst_in      (inst_in),
        .pc_in        (pc_in),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .flush        (flush),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_rd        (id_rd),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_alu_op    (id_alu_op),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .id_branch    (id_branch),
        .id_illegal   (id_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [4:0]  pc;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [3:0]  op;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
    } bundle_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_regs [32];
    bundle_t     exp_b;

    function automatic bundle_t observe();
        bundle_t o;
        o.valid = id_valid;     o.pc  = id_pc;        o.rd = id_rd;
        o.a     = id_rs_data;   o.b   = id_rt_data;   o.imm = id_imm;
        o.op    = id_alu_op;    o.rw  = id_reg_write; o.mr = id_mem_read;
        o.mw    = id_mem_write; o.br  = id_branch;    o.ill = id_illegal;
        return o;
    endfunction

    // Register read as seen at the transfer cycle, given the current wb inputs
    function automatic logic [31:0] ref_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wb_en && wb_addr == r) return wb_data;
`endif
        return model_regs[r];
    endfunction

    // Instruction semantics straight from the opcode map
    function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [4:0] pc);
        bundle_t b;
        logic [5:0] opc;
        logic [5:0] fn;
        int unsigned simm;
        opc = inst[31:26];
        fn  = inst[5:0];
        b = '0;
        b.valid = 1'b1;
        b.pc    = pc;
        b.a     = ref_read(inst[25:21]);
        b.b     = ref_read(inst[20:16]);
        simm    = inst[15] ? (32'hFFFF0000 | inst[15:0]) : {16'h0, inst[15:0]};
        b.imm   = simm;
        b.rd    = inst[20:16];
        if (opc == 6'h00) begin
            b.rd = inst[15:11];
            if      (fn == 6'h20) begin b.op = ALU_ADD; b.rw = 1; end
            else if (fn == 6'h22) begin b.op = ALU_SUB; b.rw = 1; end
            else if (fn == 6'h24) begin b.op = ALU_AND; b.rw = 1; end
            else if (fn == 6'h25) begin b.op = ALU_OR;  b.rw = 1; end
            else if (fn == 6'h2A) begin b.op = ALU_SLT; b.rw = 1; end
            else b.ill = 1;
        end
        else if (opc == 6'h08) begin b.op = ALU_ADD; b.rw = 1; end
        else if (opc == 6'h0C) begin b.op = ALU_AND; b.rw = 1; b.imm = {16'h0, inst[15:0]}; end
        else if (opc == 6'h0D) begin b.op = ALU_OR;  b.rw = 1; b.imm = {16'h0, inst[15:0]}; end
        else if (opc == 6'h23) begin b.op = ALU_ADD; b.rw = 1; b.mr = 1; end
        else if (opc == 6'h2B) begin b.op = ALU_ADD; b.mw = 1; end
        else if (opc == 6'h04) begin b.op = ALU_SUB; b.br = 1; end
        else b.ill = 1;
        return b;
    endfunction

    // One clock: check inst_ready, advance the model across the edge,
    // then check the bundle seen by execute.
    task automatic cycle();
        bundle_t nxt;
        logic    can_take;
        logic    w_en;
        logic [4:0]  w_a;
        logic [31:0] w_d;
        #1;
        can_take = !exp_b.valid || id_ready;
        n_checks++;
        if (inst_ready !== can_take) begin
            n_errors++;
            $display("FAIL inst_ready @%0t: got %b expected %b", $time, inst_ready, can_take);
        end
        nxt = exp_b;
        if (flush) nxt.valid = 1'b0;
        else begin
            if (exp_b.valid && id_ready) nxt.valid = 1'b0;
            if (inst_valid && can_take) nxt = ref_decode(inst_in, pc_in);
        end
        w_en = wb_en; w_a = wb_addr; w_d = wb_data;
        @(posedge clk);
        if (w_en && w_a != 5'd0) model_regs[w_a] = w_d;
        exp_b = nxt;
        #1;
        n_checks++;
        if (exp_b.valid) begin
            if (observe() !== exp_b) begin
                n_errors++;
                $display("FAIL bundle @%0t: got %h expected %h", $time, observe(), exp_b);
            end
        end else if (id_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL id_valid @%0t: got %b expected 0", $time, id_valid);
        end
    endtask

    task automatic idle_inputs();
        inst_valid = 0; flush = 0; wb_en = 0; id_ready = 1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        exp_b = '0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        n_checks++;
        if (observe() !== bundle_t'(0)) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected 0", observe());
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (inst_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_inst_ready: got %b expected 1", inst_ready);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        apply_reset();
        // put a bundle in and stall it, then reset mid-stall
        inst_in = 32'h00A51820; pc_in = 5'd9; inst_valid = 1; id_ready = 0;
        cycle();
        inst_in = 32'h2002FFFF; pc_in = 5'd10;
        cycle();
        apply_reset();
        idle_inputs();
        cycle();
    endtask

    task automatic test_add();
        idle_inputs();
        wb_en = 1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        cycle();
        wb_en = 0;
        inst_in = 32'h00A51820; pc_in = 5'd1; inst_valid = 1;
        cycle();
        n_checks++;
        if (id_rs_data !== 32'h1234 || id_rt_data !== 32'h1234 || id_rd !== 5'd3 ||
            id_alu_op !== ALU_ADD || id_reg_write !== 1'b1) begin
            n_errors++;
            $display("FAIL add_r5: got a=%h b=%h rd=%0d op=%0d rw=%b expected 1234 1234 3 %0d 1",
                     id_rs_data, id_rt_data, id_rd, id_alu_op, id_reg_write, ALU_ADD);
        end
        inst_valid = 0;
        cycle();
    endtask

    task automatic test_imm();
        idle_inputs();
        inst_in = 32'h2002FFFF; pc_in = 5'd2; inst_valid = 1;
        cycle();
        n_checks++;
        if (id_imm !== 32'hFFFF_FFFF || id_rd !== 5'd2) begin
            n_errors++;
            $display("FAIL addi_imm: got imm=%h rd=%0d expected ffffffff 2", id_imm, id_rd);
        end
        inst_in = 32'h3402FFFF; pc_in = 5'd3;
        cycle();
        n_checks++;
        if (id_imm !== 32'h0000_FFFF || id_rd !== 5'd2) begin
            n_errors++;
            $display("FAIL ori_imm: got imm=%h rd=%0d expected 0000ffff 2", id_imm, id_rd);
        end
        inst_valid = 0;
        cycle();
    endtask

    task automatic test_stall();
        idle_inputs();
        inst_in = 32'h00221820; pc_in = 5'd4; inst_valid = 1; id_ready = 0;
        cycle();
        inst_in = 32'h8C450004; pc_in = 5'd5;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (id_pc !== 5'd4 || inst_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_frozen: got pc=%0d ready=%b expected 4 0", id_pc, inst_ready);
            end
        end
        id_ready = 1;
        cycle();
        inst_valid = 0;
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 5'd5) begin
            n_errors++;
            $display("FAIL stall_release: got valid=%b pc=%0d expected 1 5", id_valid, id_pc);
        end
        cycle();
    endtask

    task automatic test_flush();
        idle_inputs();
        inst_in = 32'h00221822; pc_in = 5'd6; inst_valid = 1; id_ready = 0;
        cycle();
        inst_in = 32'h10220003; pc_in = 5'd7; flush = 1;
        cycle();
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_valid: got %b expected 0", id_valid);
        end
        flush = 0; inst_valid = 0; id_ready = 1;
        cycle();
        cycle();
    endtask

    task automatic test_illegal_r0();
        idle_inputs();
        inst_in = 32'hFC43_0000; pc_in = 5'd8; inst_valid = 1;
        cycle();
        n_checks++;
        if (id_illegal !== 1'b1 || id_reg_write !== 1'b0 || id_mem_read !== 1'b0 ||
            id_mem_write !== 1'b0 || id_branch !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_op: got ill=%b rw=%b mr=%b mw=%b br=%b expected 1 0 0 0 0",
                     id_illegal, id_reg_write, id_mem_read, id_mem_write, id_branch);
        end
        inst_valid = 0;
        wb_en = 1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        cycle();
        wb_en = 0;
        inst_in = 32'h0000_0820; pc_in = 5'd9; inst_valid = 1;
        cycle();
        n_checks++;
        if (id_rs_data !== 32'd0 || id_rt_data !== 32'd0) begin
            n_errors++;
            $display("FAIL r0_read: got a=%h b=%h expected 0 0", id_rs_data, id_rt_data);
        end
        inst_valid = 0;
        cycle();
    endtask

    task automatic test_same_cycle_wb();
        logic [31:0] want;
        idle_inputs();
        wb_en = 1; wb_addr = 5'd7; wb_data = 32'h1111_1111;
        cycle();
        wb_data = 32'h2222_2222;
        inst_in = 32'h00E7_4020; pc_in = 5'd10; inst_valid = 1;
        cycle();
`ifdef WB_BYPASS_EN
        want = 32'h2222_2222;
`else
        want = 32'h1111_1111;
`endif
        n_checks++;
        if (id_rs_data !== want || id_rt_data !== want) begin
            n_errors++;
            $display("FAIL same_cycle_wb: got a=%h b=%h expected %h", id_rs_data, id_rt_data, want);
        end
        wb_en = 0; inst_valid = 0;
        cycle();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[31:26] = 6'h00;
            1: begin r[31:26] = 6'h00; r[5:0] = 6'h20 + 6'($urandom_range(0, 10)); end
            2: r[31:26] = 6'h08;
            3: r[31:26] = 6'h0C;
            4: r[31:26] = 6'h0D;
            5: r[31:26] = 6'h23;
            6: r[31:26] = 6'h2B;
            7: r[31:26] = 6'h04;
            default: ;
        endcase
        return r;
    endfunction

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            inst_in    = rand_inst();
            pc_in      = 5'($urandom);
            inst_valid = ($urandom_range(0, 9) < 7);
            id_ready   = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 31) == 0);
            wb_en      = $urandom_range(0, 1) == 1;
            wb_addr    = 5'($urandom);
            wb_data    = $urandom;
            cycle();
        end
        idle_inputs();
        cycle();
    endtask

    initial begin
        exp_b = '0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        test_reset();
        test_add();
        test_imm();
        test_stall();
        test_flush();
        test_illegal_r0();
        test_same_cycle_wb();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_decode_stage
`default_nettype wire
